// File: rtl/mips_pkg.sv
// Shared constants for the MIPS-style datapath blocks.
// Provides default register-file widths and the hardwired zero register index.
package mips_pkg;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int REG_ZERO = 0;

endpackage

// File: rtl/rf_read_port.sv
// One combinational register-file read port: zero check, optional bypass, mux.
// Ports: addr, regs (storage), wrEn/wrAddr/wrData (bypass source), readData.
// Macro REG_BYPASS_EN enables same-cycle write-through.
module rf_read_port
    import mips_pkg::*;
#(
    parameter int DATA_W = mips_pkg::DATA_W,
    parameter int ADDR_W = mips_pkg::ADDR_W
) (
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] regs [2**ADDR_W],
    input  logic              wrEn,
    input  logic [ADDR_W-1:0] wrAddr,
    input  logic [DATA_W-1:0] wrData,
    output logic [DATA_W-1:0] readData
);

    localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(REG_ZERO);

`ifdef REG_BYPASS_EN
    logic bypassHit;

    // wrEn arrives already qualified by reset; address 0 never forwards
    assign bypassHit = wrEn && (wrAddr == addr) && (addr != ZERO_ADDR);

    always_comb begin
        readData = '0;
        unique case (1'b1)
            (addr == ZERO_ADDR): readData = '0;
            bypassHit:           readData = wrData;
            default:             readData = regs[addr];
        endcase
    end
`else
    logic unusedBypass;

    assign unusedBypass = ^{wrEn, wrAddr, wrData};

    always_comb begin
        readData = '0;
        unique case (1'b1)
            (addr == ZERO_ADDR): readData = '0;
            default:             readData = regs[addr];
        endcase
    end
`endif

endmodule

// File: rtl/register_file.sv
// 2-read / 1-write register file with register 0 hardwired to zero.
// Ports: clk, rst_n, rs/rt (read addr), rd/regWrite/writeData, readData1/2.
// Macro REG_BYPASS_EN enables same-cycle write-through on the read ports.
module register_file
    import mips_pkg::*;
#(
    parameter int DATA_W = mips_pkg::DATA_W,
    parameter int ADDR_W = mips_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] rs,
    input  logic [ADDR_W-1:0] rt,
    input  logic [ADDR_W-1:0] rd,
    input  logic              regWrite,
    input  logic [DATA_W-1:0] writeData,
    output logic [DATA_W-1:0] readData1,
    output logic [DATA_W-1:0] readData2
);

    localparam int DEPTH = 2**ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(REG_ZERO);

    logic [DATA_W-1:0] regs [DEPTH];
    logic              wrEn;

    // Writes (and bypass) are suppressed while reset is held
    assign wrEn = regWrite && rst_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (wrEn && (rd != ZERO_ADDR)) begin
            regs[rd] <= writeData;
        end
    end

    rf_read_port #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_port1 (
        .addr     (rs),
        .regs     (regs),
        .wrEn     (wrEn),
        .wrAddr   (rd),
        .wrData   (writeData),
        .readData (readData1)
    );

    rf_read_port #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_port2 (
        .addr     (rt),
        .regs     (regs),
        .wrEn     (wrEn),
        .wrAddr   (rd),
        .wrData   (writeData),
        .readData (readData2)
    );

endmodule

// File: tb/tb_register_file.sv
// Directed self-checking bench for register_file.
// Expected values are hand-computed constants; honours REG_BYPASS_EN.
module tb_register_file;

    logic        clk;
    logic        rst_n;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic        regWrite;
    logic [31:0] writeData;
    logic [31:0] readData1;
    logic [31:0] readData2;

    int passCnt  = 0;
    int checkCnt = 0;

    register_file dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rs        (rs),
        .rt        (rt),
        .rd        (rd),
        .regWrite  (regWrite),
        .writeData (writeData),
        .readData1 (readData1),
        .readData2 (readData2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        checkCnt++;
        if (got === exp) begin
            passCnt++;
        end else begin
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        @(negedge clk);
        rd        = a;
        writeData = d;
        regWrite  = 1'b1;
        @(negedge clk);
        regWrite  = 1'b0;
    endtask

    initial begin
        rst_n     = 1'b0;
        rs        = '0;
        rt        = '0;
        rd        = '0;
        regWrite  = 1'b0;
        writeData = '0;

        // reset state
        repeat (2) @(negedge clk);
        check("rst_rd1", readData1, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        check("post_rst_rd1", readData1, 32'd0);
        check("post_rst_rd2", readData2, 32'd0);

        // basic write then read
        wr(5'd1, 32'd9);
        rt = 5'd1;
        #1;
        check("r1_rd2", readData2, 32'd9);
        rs = 5'd1;
        #1;
        check("r1_rd1", readData1, 32'd9);
        check("r1_same", readData1, readData2);

        // write to r0 discarded
        wr(5'd0, 32'hFFFF_FFFF);
        rs = 5'd0;
        rt = 5'd0;
        #1;
        check("r0_rd1", readData1, 32'd0);
        check("r0_rd2", readData2, 32'd0);

        // async reset mid-cycle clears storage and kills pending write
        @(negedge clk);
        rs        = 5'd1;
        rd        = 5'd6;
        writeData = 32'd66;
        regWrite  = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_r1", readData1, 32'd0);
        rt = 5'd6;
        #1;
        check("rst_rd_r6", readData2, 32'd0);
        @(posedge clk);
        #1;
        check("rst_blocks_wr", readData2, 32'd0);

        // first write accepted on first edge after release
        @(negedge clk);
        rd        = 5'd4;
        writeData = 32'h44;
        rst_n     = 1'b1;
        @(negedge clk);
        regWrite = 1'b0;
        rs = 5'd4;
        rt = 5'd6;
        #1;
        check("first_wr_r4", readData1, 32'h44);
        check("pending_r6", readData2, 32'd0);
        rs = 5'd1;
        #1;
        check("r1_cleared", readData1, 32'd0);

        // same-cycle visibility
        @(negedge clk);
        rs        = 5'd2;
        rt        = 5'd2;
        rd        = 5'd2;
        writeData = 32'd7;
        regWrite  = 1'b1;
        #1;
`ifdef REG_BYPASS_EN
        check("byp_rd1", readData1, 32'd7);
        check("byp_rd2", readData2, 32'd7);
`else
        check("nobyp_rd1", readData1, 32'd0);
        check("nobyp_rd2", readData2, 32'd0);
`endif
        @(negedge clk);
        regWrite = 1'b0;
        #1;
        check("after_edge_rd1", readData1, 32'd7);

        // write to r0 never forwards
        @(negedge clk);
        rs        = 5'd0;
        rd        = 5'd0;
        writeData = 32'h1234;
        regWrite  = 1'b1;
        #1;
        check("r0_no_byp", readData1, 32'd0);
        @(negedge clk);
        regWrite = 1'b0;

        // fill and sweep
        for (int i = 1; i < 32; i++) begin
            wr(5'(i), 32'(i * 3));
        end
        for (int i = 0; i < 32; i++) begin
            rs = 5'(i);
            rt = 5'(31 - i);
            #1;
            check($sformatf("sweep_rs%0d", i), readData1, 32'(i * 3));
            check($sformatf("sweep_rt%0d", 31 - i), readData2,
                  32'((31 - i) * 3));
        end

        // regWrite=0 leaves storage unchanged
        @(negedge clk);
        rd        = 5'd5;
        writeData = 32'hDEAD;
        regWrite  = 1'b0;
        @(negedge clk);
        rs = 5'd5;
        rt = 5'd5;
        #1;
        check("nowr_r5_rd1", readData1, 32'd15);
        check("nowr_r5_rd2", readData2, 32'd15);

        $display("%0d/%0d checks passed", passCnt, checkCnt);
        $finish;
    end

endmodule

// File: doc/register_file.md
REGISTER_FILE -- requirements
Module: register_file

Interface
REQ-001 SHALL have parameter DATA_W, default 32, register and data width in bits.
REQ-002 SHALL have parameter ADDR_W, default 5, register address width; depth = 2**ADDR_W (32 registers).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port rs, input, ADDR_W bits: read address, port 1.
REQ-006 SHALL have port rt, input, ADDR_W bits: read address, port 2.
REQ-007 SHALL have port rd, input, ADDR_W bits: write address.
REQ-008 SHALL have port regWrite, input, 1 bit: write enable.
REQ-009 SHALL have port writeData, input, DATA_W bits: write data.
REQ-010 SHALL have port readData1, output, DATA_W bits: contents of register rs.
REQ-011 SHALL have port readData2, output, DATA_W bits: contents of register rt.
REQ-012 SHALL use one clock; reset SHALL be asynchronous and active-low.

Function
REQ-013 SHALL, on a rising clk edge with rst_n=1, regWrite=1 and rd!=0, store writeData into register rd.
REQ-014 SHALL leave all registers unchanged on an edge with regWrite=0.
REQ-015 SHALL hardwire register 0: writes to rd=0 are discarded, and reads of address 0 return 0 on both ports.
REQ-016 SHALL drive readData1 and readData2 combinationally from rs and rt, with zero-cycle read latency.
REQ-017 SHALL return the same value on both ports when rs==rt.
REQ-018 SHALL make written data visible on reads in the cycle after the write edge (one-cycle write-to-read latency, unless REG_BYPASS_EN is defined).
REQ-019 SHALL NOT produce X on any output after reset for any address value.

Reset
REQ-020 SHALL clear all registers to 0 immediately when rst_n falls, independent of clk.
REQ-021 SHALL block writes while rst_n=0; the first write is accepted on the first rising edge with rst_n=1.
REQ-022 SHALL, on reset asserted mid-operation, discard any pending write, and reads SHALL return 0 during reset.

Configuration
REQ-023 SHALL support macro REG_BYPASS_EN.
- Defined: when regWrite=1, rd!=0 and rd==rs (or rd==rt), the matching read port returns writeData combinationally in the same cycle (write-through).
- Undefined: reads return the stored value only; the new value appears after the write edge.

Structure
REQ-024 SHALL take DATA_W and ADDR_W defaults and the constant REG_ZERO=0 from shared package mips_pkg.
REQ-025 SHALL implement each read port as one sub-module instance, rf_read_port (zero check, optional bypass, mux), instantiated twice.
REQ-026 SHALL hold storage as an array of 2**ADDR_W registers of DATA_W bits inside register_file.

Verification
REQ-027 Reset, then rs=0, rt=0 -> readData1=0, readData2=0.
REQ-028 rd=1, writeData=9, regWrite=1 for one edge, then regWrite=0, rt=1 -> readData2=9; rs=1 -> readData1=9.
REQ-029 rd=0, writeData=32'hFFFFFFFF, regWrite=1 for one edge, then rs=0 -> readData1=0.
REQ-030 Write 9 to r1, pulse rst_n low between clock edges, then rs=1 -> readData1=0 immediately; a write during rst_n=0 is ignored.
REQ-031 With REG_BYPASS_EN: rd=rs=2, writeData=7, regWrite=1 before the edge -> readData1=7 in the same cycle. Without REG_BYPASS_EN: readData1=0 before the edge and 7 after it.
REQ-032 Write distinct values (register index times 3) to r1..r31, then sweep rs and rt over all addresses -> each port returns index times 3; address 0 returns 0.
